sum_hex_uart_tx: RTL
====================

# sum_hex_uart_tx

Downstream consumer of the nibble adder stage. Accepts 4-bit sums over a valid/ready handshake and buffers them in a small FIFO. Each sum is sent as one ASCII hex character ('0'-'9', 'A'-'F') on an 8N1 serial line, so results can be read off a single output pin with a USB-UART adapter.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per serial bit. Legal values are 2 to 65535.
- FIFO_DEPTH, default 4: number of FIFO entries. Must be a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_sum holds a result to enqueue
- in_sum  in  4  sum value, unsigned 0-15
- in_ready  out  1  FIFO can accept an entry; equals (count != FIFO_DEPTH)
- tx  out  1  serial output; idles high
- busy  out  1  high whenever the transmitter state is not IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued entries, 0 to FIFO_DEPTH

## Operation
- **Push.** A push happens on an edge where in_valid and in_ready are both 1; in_sum is written at the write pointer.
  - in_valid with in_ready=0 has no effect. The producer must hold the data.
  - in_ready depends on registered count only. When the FIFO is full, in_ready=0 even if a pop occurs on the same edge.
- **Pop.** A pop happens on an edge where the transmitter is in IDLE and count > 0.
  - The head entry is converted to ASCII and loaded into an 8-bit shift register.
  - The state goes to START.
- **Count update.** A push and a pop on the same edge leave the count unchanged. Pointers are FIFO_DEPTH-modulo and wrap silently.
- **ASCII conversion:**
  - 0-9 maps to 8'h30-8'h39.
  - 10-15 maps to 8'h41-8'h46 (uppercase).
- **Transmitter FSM** uses a bit timer counting 0 to CLKS_PER_BIT-1 and a 3-bit index:
  - IDLE: tx=1. Pop when count > 0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: tx = shift[index], LSB first. Each bit lasts CLKS_PER_BIT cycles. After index 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is a registered output, so there are no glitches.
- **Reset values** (applied immediately on reset assertion):
  - tx=1, busy=0, fifo_count=0, in_ready=1.
  - State IDLE; pointers and timer at 0.
- **Reset mid-frame** aborts the frame: tx returns to 1 immediately and all queued entries are discarded. Nothing resumes after release.

## Timing
- **Push to start bit:**
  - Push at edge N: fifo_count=1 after edge N.
  - Pop at edge N+1: tx=0 and busy=1 after edge N+1.
- **Frame length:** 10*CLKS_PER_BIT cycles from tx falling to the return to IDLE.
- **Inter-frame gap:** at least 1 cycle of tx=1 in IDLE between back-to-back frames. The gap after a stop bit is therefore CLKS_PER_BIT+1 high cycles.
- **Sustained throughput:** one character per 10*CLKS_PER_BIT+1 cycles.
- **Freeing a full FIFO:** in_ready rises the cycle after the edge that pops.
- in_sum is sampled only on push edges; its value at other times is don't-care.

## Test plan
- **Single char.** CLKS_PER_BIT=4; push in_sum=7.
  - tx falls 1 cycle after the push.
  - Bits 0,1,1,1,0,1,1,0,0 then 1 (start, 0x37 LSB first, stop), 4 cycles each.
  - busy drops after 40 cycles.
- **Letter mapping.** Push 10, then 15. Decoded frames are 0x41 then 0x46, separated by exactly 5 high cycles.
- **Backpressure.** FIFO_DEPTH=4; hold in_valid=1 with values 0-5 on successive edges.
  - 5 are accepted: 1 is popped immediately, then count reaches 4 and in_ready=0.
  - The 6th is accepted the cycle after the second pop.
  - Output sequence is '0','1','2','3','4','5'.
- **Simultaneous push/pop.** With count=2, push on the pop edge. Count stays 2 and order is preserved.
- **Reset mid-frame.** Assert reset during DATA bit 3 with 2 entries queued.
  - tx=1, busy=0, fifo_count=0 immediately.
  - After release, tx stays high with no further frames.
- **Pointer wrap.** Push and drain 9 values with FIFO_DEPTH=4. All 9 characters come out in order with no duplicates.

Source files
------------

// File: rtl/sum_hex_uart_tx.sv
// Buffers 4-bit sums in a small FIFO and sends each one as an ASCII hex
// character ('0'-'9', 'A'-'F') on an 8N1 serial line.
module sum_hex_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [3:0]                    in_sum,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [PW:0]   DEPTH_C    = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;

    function automatic logic [7:0] to_ascii(input logic [3:0] v);
        // 0x37 + 10 = 'A'
        if (v < 4'd10) return 8'h30 + {4'h0, v};
        else           return 8'h37 + {4'h0, v};
    endfunction

    assign in_ready   = (count_q != DEPTH_C);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (!push && pop) count_d = count_q - CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (pop) begin
                    shift_d = to_ascii(mem_q[rd_ptr_q]);
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_sum;
    end

endmodule
